// File: rtl/vga_csr_if.sv
// Native register bus between the AXI-Lite slave FSM and the VGA CSR block.
interface vga_csr_if #(
    parameter int AXIL_DATA_WIDTH   = 32,
    parameter int NATIVE_ADDR_WIDTH = 4
);
    logic                         write_en_i;
    logic [NATIVE_ADDR_WIDTH-1:0] addr_write_i;
    logic [AXIL_DATA_WIDTH-1:0]   data_i;
    logic                         read_en_i;
    logic [NATIVE_ADDR_WIDTH-1:0] addr_read_i;
    logic [AXIL_DATA_WIDTH-1:0]   data_o;

    modport master (
        output write_en_i, addr_write_i, data_i, read_en_i, addr_read_i,
        input  data_o
    );

    modport slave (
        input  write_en_i, addr_write_i, data_i, read_en_i, addr_read_i,
        output data_o
    );
endinterface

// File: rtl/vga_csr.sv
// VGA control/status registers: CTRL, W1C interrupt status, mask, frame
// counter, framebuffer base and scratch. All outputs come straight from flops.
module vga_csr #(
    parameter int AXIL_DATA_WIDTH   = 32,
    parameter int NATIVE_ADDR_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       arst_ni,
    vga_csr_if.slave                   bus,
    input  logic                       frame_done_i,
    input  logic                       underflow_i,
    output logic                       enable_o,
    output logic                       test_pattern_o,
    output logic [1:0]                 mode_o,
    output logic [AXIL_DATA_WIDTH-1:0] fb_base_o,
    output logic                       irq_o
);
    localparam int DW = AXIL_DATA_WIDTH;
    localparam int AW = NATIVE_ADDR_WIDTH;

    localparam logic [AW-1:0] ADDR_CTRL    = AW'(0);
    localparam logic [AW-1:0] ADDR_STATUS  = AW'(1);
    localparam logic [AW-1:0] ADDR_MASK    = AW'(2);
    localparam logic [AW-1:0] ADDR_FRMCNT  = AW'(3);
    localparam logic [AW-1:0] ADDR_FBBASE  = AW'(4);
    localparam logic [AW-1:0] ADDR_SCRATCH = AW'(5);

    logic [3:0]    ctrl_q;
    logic [1:0]    status_q;
    logic [1:0]    mask_q;
    logic [DW-1:0] frame_cnt_q;
    logic [DW-1:0] fb_base_q;
    logic [DW-1:0] scratch_q;
    logic [DW-1:0] rdata_q;
    logic          irq_q;

    logic          wr_ctrl, wr_status, wr_mask, wr_fbbase, wr_scratch;
    logic          cnt_clr;
    logic [1:0]    status_nxt;
    logic [1:0]    mask_nxt;
    logic [DW-1:0] frame_cnt_nxt;
    logic [DW-1:0] rd_mux;

    // Write decode and next-state for the event-driven registers.
    always_comb begin
        wr_ctrl    = bus.write_en_i && (bus.addr_write_i == ADDR_CTRL);
        wr_status  = bus.write_en_i && (bus.addr_write_i == ADDR_STATUS);
        wr_mask    = bus.write_en_i && (bus.addr_write_i == ADDR_MASK);
        wr_fbbase  = bus.write_en_i && (bus.addr_write_i == ADDR_FBBASE);
        wr_scratch = bus.write_en_i && (bus.addr_write_i == ADDR_SCRATCH);
        cnt_clr    = wr_ctrl && bus.data_i[4];

        // Clear first, then OR in events so a coincident pulse wins.
        status_nxt = status_q;
        if (wr_status) status_nxt = status_nxt & ~bus.data_i[1:0];
        status_nxt = status_nxt | {underflow_i, frame_done_i};

        mask_nxt = wr_mask ? bus.data_i[1:0] : mask_q;

        frame_cnt_nxt = frame_cnt_q;
        if (cnt_clr)           frame_cnt_nxt = '0;
        else if (frame_done_i) frame_cnt_nxt = frame_cnt_q + DW'(1);
    end

    // Read mux on current (pre-write, pre-increment) register contents.
    always_comb begin
        rd_mux = '0;
        case (bus.addr_read_i)
            ADDR_CTRL:    rd_mux = DW'(ctrl_q);
            ADDR_STATUS:  rd_mux = DW'(status_q);
            ADDR_MASK:    rd_mux = DW'(mask_q);
            ADDR_FRMCNT:  rd_mux = frame_cnt_q;
            ADDR_FBBASE:  rd_mux = fb_base_q;
            ADDR_SCRATCH: rd_mux = scratch_q;
            default:      rd_mux = '0;
        endcase
    end

    // Register state; irq is registered from next-state so it tracks status/mask.
    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            ctrl_q      <= '0;
            status_q    <= '0;
            mask_q      <= '0;
            frame_cnt_q <= '0;
            fb_base_q   <= '0;
            scratch_q   <= '0;
            rdata_q     <= '0;
            irq_q       <= 1'b0;
        end else begin
            if (wr_ctrl)    ctrl_q    <= bus.data_i[3:0];
            if (wr_fbbase)  fb_base_q <= bus.data_i;
            if (wr_scratch) scratch_q <= bus.data_i;
            if (bus.read_en_i) rdata_q <= rd_mux;
            status_q    <= status_nxt;
            mask_q      <= mask_nxt;
            frame_cnt_q <= frame_cnt_nxt;
            irq_q       <= |(status_nxt & mask_nxt);
        end
    end

    assign bus.data_o     = rdata_q;
    assign enable_o       = ctrl_q[0];
    assign test_pattern_o = ctrl_q[1];
    assign mode_o         = ctrl_q[3:2];
    assign fb_base_o      = fb_base_q;
    assign irq_o          = irq_q;
endmodule

// File: tb/tb_vga_csr.sv
// Self-checking bench for vga_csr: vector table plus directed corner sequences.
module tb_vga_csr;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        frame_done = 1'b0;
    logic        underflow = 1'b0;
    logic        enable;
    logic        test_pattern;
    logic [1:0]  mode;
    logic [31:0] fb_base;
    logic        irq;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] exp;
    } rd_t;
    rd_t sb[$];

    typedef struct {
        bit          wr;
        logic [3:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vga_csr_if bus ();

    vga_csr dut (
        .clk_i          (clk),
        .arst_ni        (rst_n),
        .bus            (bus),
        .frame_done_i   (frame_done),
        .underflow_i    (underflow),
        .enable_o       (enable),
        .test_pattern_o (test_pattern),
        .mode_o         (mode),
        .fb_base_o      (fb_base),
        .irq_o          (irq)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    // Scoreboard consumer: a read issued at this edge returns data just after it.
    always @(posedge clk) begin
        if (rst_n && bus.read_en_i === 1'b1) begin
            #1;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL read_unexpected: got 0x%08h expected no read", bus.data_o);
            end else begin
                rd_t r;
                r = sb.pop_front();
                check($sformatf("read_addr%0d", r.addr), bus.data_o, r.exp);
            end
        end
    end

    // All drive tasks start and end at a negative edge.
    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        bus.write_en_i = 1'b1; bus.addr_write_i = a; bus.data_i = d;
        @(negedge clk);
        bus.write_en_i = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, input logic [31:0] e);
        rd_t r;
        r.addr = a; r.exp = e;
        sb.push_back(r);
        bus.read_en_i = 1'b1; bus.addr_read_i = a;
        @(negedge clk);
        bus.read_en_i = 1'b0;
    endtask

    task automatic pulse_frame();
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
    endtask

    vec_t vecs[12];

    initial begin
        logic [31:0] held;
        vecs = '{
            '{1'b1, 4'd5, 32'hDEADBEEF, 32'h0},
            '{1'b1, 4'd4, 32'h00010000, 32'h0},
            '{1'b0, 4'd5, 32'h0,        32'hDEADBEEF},
            '{1'b0, 4'd4, 32'h0,        32'h00010000},
            '{1'b1, 4'd2, 32'hFFFFFFFF, 32'h0},
            '{1'b0, 4'd2, 32'h0,        32'h00000003},
            '{1'b1, 4'd0, 32'hFFFFFFEF, 32'h0},
            '{1'b0, 4'd0, 32'h0,        32'h0000000F},
            '{1'b1, 4'd3, 32'h12345678, 32'h0},
            '{1'b0, 4'd3, 32'h0,        32'h00000000},
            '{1'b1, 4'd6, 32'hCAFEF00D, 32'h0},
            '{1'b0, 4'd6, 32'h0,        32'h00000000}
        };
        bus.write_en_i = 1'b0; bus.read_en_i = 1'b0;
        bus.addr_write_i = '0; bus.addr_read_i = '0; bus.data_i = '0;

        // Reset held across clock edges.
        repeat (3) @(negedge clk);
        check("rst_enable", 32'(enable), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_data_o", bus.data_o, 32'h0);
        check("rst_fb_base", fb_base, 32'h0);
        rst_n = 1'b1;

        for (int a = 0; a < 8; a++) rd(4'(a), 32'h0);

        for (int i = 0; i < 12; i++) begin
            if (vecs[i].wr) wr(vecs[i].addr, vecs[i].data);
            else            rd(vecs[i].addr, vecs[i].exp);
        end
        check("fb_base_o", fb_base, 32'h00010000);
        check("ctrl_outs", {28'h0, mode, test_pattern, enable}, 32'h0000000F);

        // data_o holds between reads.
        held = bus.data_o;
        repeat (3) @(negedge clk);
        check("data_o_hold", bus.data_o, 32'h0);
        check("data_o_hold_same", bus.data_o, held);

        // Interrupt path.
        wr(4'd0, 32'h0);
        wr(4'd2, 32'h1);
        pulse_frame();
        check("irq_set", 32'(irq), 32'h1);
        rd(4'd1, 32'h1);
        wr(4'd1, 32'h1);
        check("irq_clr", 32'(irq), 32'h0);
        rd(4'd1, 32'h0);
        underflow = 1'b1; @(negedge clk); underflow = 1'b0;
        rd(4'd1, 32'h2);
        check("irq_masked", 32'(irq), 32'h0);
        wr(4'd1, 32'h2);
        rd(4'd1, 32'h0);

        // W1C and frame_done in the same cycle: set wins.
        frame_done = 1'b1;
        wr(4'd1, 32'h1);
        frame_done = 1'b0;
        rd(4'd1, 32'h1);
        check("irq_set_wins", 32'(irq), 32'h1);
        wr(4'd1, 32'h1);

        // Same-cycle read and write of SCRATCH returns the old value.
        bus.read_en_i = 1'b1; bus.addr_read_i = 4'd5;
        sb.push_back('{4'd5, 32'hDEADBEEF});
        wr(4'd5, 32'h5A5A0001);
        bus.read_en_i = 1'b0;
        rd(4'd5, 32'h5A5A0001);

        // Frame counter: clear, count, read during increment, clear vs increment.
        wr(4'd0, 32'h10);
        rd(4'd3, 32'h0);
        repeat (5) pulse_frame();
        rd(4'd3, 32'h5);
        frame_done = 1'b1;
        rd(4'd3, 32'h5);
        frame_done = 1'b0;
        rd(4'd3, 32'h6);
        frame_done = 1'b1;
        wr(4'd0, 32'h10);
        frame_done = 1'b0;
        rd(4'd3, 32'h0);
        repeat (5) pulse_frame();
        rd(4'd3, 32'h5);
        wr(4'd0, 32'h13);
        rd(4'd3, 32'h0);
        rd(4'd0, 32'h3);
        check("ctrl13_outs", {28'h0, mode, test_pattern, enable}, 32'h00000003);

        // Asynchronous reset mid-operation.
        wr(4'd0, 32'hF);
        wr(4'd4, 32'h00ABC000);
        wr(4'd2, 32'h1);
        pulse_frame();
        rd(4'd4, 32'h00ABC000);
        check("pre_rst_irq", 32'(irq), 32'h1);
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        check("arst_ctrl_outs", {28'h0, mode, test_pattern, enable}, 32'h0);
        check("arst_fb_base", fb_base, 32'h0);
        check("arst_irq", 32'(irq), 32'h0);
        check("arst_data_o", bus.data_o, 32'h0);
        #99;
        @(negedge clk);
        rst_n = 1'b1;
        rd(4'd0, 32'h0);
        rd(4'd3, 32'h0);
        rd(4'd1, 32'h0);

        repeat (2) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
